// File: rtl/cntr_timer_pkg.sv
// Shared types and constants for the mod-n counter/timer.
// Direction and mode encodings match the raw port levels.
package cntr_timer_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;
  localparam logic DIR_UP        = 1'b0;
  localparam logic DIR_DOWN      = 1'b1;

endpackage

// File: rtl/cntr_ovf_tally.sv
// Sticky overflow flag plus saturating overflow counter; updates on the cycle after set.
// A coincident clr is applied before set, so clr+set leaves sticky=1, cnt=1.
module cntr_ovf_tally #(
  parameter int OVF_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 set,
  output logic                 sticky_o,
  output logic [OVF_CNT_W-1:0] cnt_o
);

  localparam logic [OVF_CNT_W-1:0] CNT_ONE = OVF_CNT_W'(1);

  logic                 sticky_q, sticky_d;
  logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sticky_d = clr ? 1'b0 : sticky_q;
    cnt_d    = clr ? '0 : cnt_q;
    if (set) begin
      sticky_d = 1'b1;
      if (cnt_d != '1) cnt_d = cnt_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky_o = sticky_q;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/cntr_mod_n_timer.sv
// Programmable mod-n counter/timer: up/down, periodic/one-shot, shadow-latched modulus.
// stop beats start; a terminal tick reloads and pulses ovf on the following cycle.
module cntr_mod_n_timer
  import cntr_timer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OVF_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 enb,
  input  logic                 mode,
  input  logic                 dir,
  input  logic [WIDTH-1:0]     count_max,
  input  logic                 ovf_clr,
  output logic [WIDTH-1:0]     cntr_o,
  output logic                 ovf,
  output logic                 ovf_sticky,
  output logic [OVF_CNT_W-1:0] ovf_cnt,
  output logic                 busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cntr_q, cntr_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic             ovf_q, ovf_d;
  logic             terminal;

  assign terminal = (dir_q == DIR_DOWN) ? (cntr_q == '0) : (cntr_q == max_q);

  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    max_d   = max_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    ovf_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      max_d   = count_max;
      dir_d   = dir;
      mode_d  = mode;
      cntr_d  = (dir == DIR_DOWN) ? count_max : '0;
    end else if (state_q == RUN && enb) begin
      if (terminal) begin
        // Reload doubles as the one-shot resting value.
        cntr_d = (dir_q == DIR_DOWN) ? max_q : '0;
        ovf_d  = 1'b1;
        if (mode_q == MODE_ONESHOT) state_d = IDLE;
      end else begin
        cntr_d = (dir_q == DIR_DOWN) ? cntr_q - ONE : cntr_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cntr_q  <= '0;
      max_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= MODE_PERIODIC;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      max_q   <= max_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  cntr_ovf_tally #(.OVF_CNT_W(OVF_CNT_W)) u_tally (
    .clk      (clk),
    .rst      (rst),
    .clr      (ovf_clr),
    .set      (ovf_d),
    .sticky_o (ovf_sticky),
    .cnt_o    (ovf_cnt)
  );

  assign cntr_o = cntr_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == RUN);

endmodule

// File: tb/tb_cntr_mod_n_timer.sv
// Directed bench for cntr_mod_n_timer; expected values are hand-computed per scenario.
module tb_cntr_mod_n_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, enb, mode, dir, ovf_clr;
  logic [7:0] count_max;
  logic [7:0] cntr_o;
  logic       ovf, ovf_sticky, busy;
  logic [3:0] ovf_cnt;

  int vecs = 0;
  int errs = 0;

  cntr_mod_n_timer #(.WIDTH(8), .OVF_CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .enb        (enb),
    .mode       (mode),
    .dir        (dir),
    .count_max  (count_max),
    .ovf_clr    (ovf_clr),
    .cntr_o     (cntr_o),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_cnt    (ovf_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Inputs set before step() are sampled at its edge; outputs are read 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] mx, input logic d, input logic m);
    start = 1'b1; count_max = mx; dir = d; mode = m; enb = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    vecs++; if (cntr_o !== 8'd0) begin errs++; $display("FAIL rst_cntr got %0d want 0", cntr_o); end
    vecs++; if ({ovf, ovf_sticky, busy} !== 3'b000) begin errs++; $display("FAIL rst_flags got %b want 000", {ovf, ovf_sticky, busy}); end
    vecs++; if (ovf_cnt !== 4'd0) begin errs++; $display("FAIL rst_ovf_cnt got %0d want 0", ovf_cnt); end
    rst = 1'b0;
    do_start(8'd9, 1'b0, 1'b0);
    enb = 1'b1;
    repeat (5) step();
    vecs++; if (cntr_o !== 8'd5) begin errs++; $display("FAIL pre_rst_cntr got %0d want 5", cntr_o); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (cntr_o !== 8'd0) begin errs++; $display("FAIL async_rst_cntr got %0d want 0", cntr_o); end
    vecs++; if ({ovf, ovf_sticky, busy, ovf_cnt} !== 7'd0) begin errs++; $display("FAIL async_rst_flags got %b want 0", {ovf, ovf_sticky, busy, ovf_cnt}); end
    step();
    rst = 1'b0;
    step();
    vecs++; if (busy !== 1'b0 || cntr_o !== 8'd0) begin errs++; $display("FAIL post_rst got busy=%b cntr=%0d want busy=0 cntr=0", busy, cntr_o); end
    enb = 1'b0;
  endtask

  task automatic test_periodic_up();
    do_start(8'd3, 1'b0, 1'b0);
    vecs++; if (busy !== 1'b1 || cntr_o !== 8'd0) begin errs++; $display("FAIL pu_start got busy=%b cntr=%0d want 1/0", busy, cntr_o); end
    enb = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      step();
      vecs++; if (cntr_o !== 8'(i % 4)) begin errs++; $display("FAIL pu_cntr tick %0d got %0d want %0d", i, cntr_o, i % 4); end
      vecs++; if (ovf !== (i % 4 == 0)) begin errs++; $display("FAIL pu_ovf tick %0d got %b want %b", i, ovf, (i % 4 == 0)); end
      if (i == 40) begin
        vecs++; if (ovf_cnt !== 4'd10) begin errs++; $display("FAIL pu_cnt10 got %0d want 10", ovf_cnt); end
      end
    end
    vecs++; if (ovf_cnt !== 4'd15 || ovf_sticky !== 1'b1) begin errs++; $display("FAIL pu_sat got cnt=%0d sticky=%b want 15/1", ovf_cnt, ovf_sticky); end
    enb = 1'b0;
  endtask

  task automatic test_oneshot_down();
    stop = 1'b1; ovf_clr = 1'b1;
    step();
    stop = 1'b0; ovf_clr = 1'b0;
    vecs++; if ({busy, ovf_sticky, ovf_cnt} !== 6'd0) begin errs++; $display("FAIL od_clr got %b want 0", {busy, ovf_sticky, ovf_cnt}); end
    do_start(8'd2, 1'b1, 1'b1);
    vecs++; if (cntr_o !== 8'd2 || busy !== 1'b1) begin errs++; $display("FAIL od_load got cntr=%0d busy=%b want 2/1", cntr_o, busy); end
    enb = 1'b1;
    step();
    vecs++; if (cntr_o !== 8'd1 || ovf !== 1'b0) begin errs++; $display("FAIL od_c1 got cntr=%0d ovf=%b want 1/0", cntr_o, ovf); end
    step();
    vecs++; if (cntr_o !== 8'd0 || ovf !== 1'b0) begin errs++; $display("FAIL od_c0 got cntr=%0d ovf=%b want 0/0", cntr_o, ovf); end
    step();
    vecs++; if ({cntr_o, ovf, busy} !== {8'd2, 1'b1, 1'b0}) begin errs++; $display("FAIL od_term got cntr=%0d ovf=%b busy=%b want 2/1/0", cntr_o, ovf, busy); end
    vecs++; if (ovf_sticky !== 1'b1 || ovf_cnt !== 4'd1) begin errs++; $display("FAIL od_tally got sticky=%b cnt=%0d want 1/1", ovf_sticky, ovf_cnt); end
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++; if ({cntr_o, ovf, busy} !== {8'd2, 1'b0, 1'b0}) begin errs++; $display("FAIL od_idle got cntr=%0d ovf=%b busy=%b want 2/0/0", cntr_o, ovf, busy); end
    end
    vecs++; if (ovf_cnt !== 4'd1) begin errs++; $display("FAIL od_cnt_hold got %0d want 1", ovf_cnt); end
    enb = 1'b0;
  endtask

  task automatic test_max_zero();
    logic [3:0] pat;
    pat = 4'b1101;
    do_start(8'd0, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      enb = pat[i];
      step();
      vecs++; if (ovf !== pat[i] || cntr_o !== 8'd0) begin errs++; $display("FAIL mz_ovf step %0d got ovf=%b cntr=%0d want %b/0", 3 - i, ovf, cntr_o, pat[i]); end
    end
    enb = 1'b0;
    step();
    vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL mz_idle_enb got ovf=%b want 0", ovf); end
    count_max = 8'd7; dir = 1'b1; mode = 1'b1;
    enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (ovf !== 1'b1 || cntr_o !== 8'd0 || busy !== 1'b1) begin errs++; $display("FAIL mz_shadow got ovf=%b cntr=%0d busy=%b want 1/0/1", ovf, cntr_o, busy); end
    end
    do_start(8'd7, 1'b0, 1'b0);
    enb = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      vecs++; if (ovf !== (i == 8) || cntr_o !== 8'(i % 8)) begin errs++; $display("FAIL mz_restart tick %0d got ovf=%b cntr=%0d want %b/%0d", i, ovf, cntr_o, (i == 8), i % 8); end
    end
  endtask

  task automatic test_collisions();
    repeat (3) step();
    stop = 1'b1; start = 1'b1; count_max = 8'd5; dir = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    vecs++; if (busy !== 1'b0 || cntr_o !== 8'd3) begin errs++; $display("FAIL co_stopstart got busy=%b cntr=%0d want 0/3", busy, cntr_o); end
    step();
    vecs++; if (cntr_o !== 8'd3 || ovf !== 1'b0) begin errs++; $display("FAIL co_idle got cntr=%0d ovf=%b want 3/0", cntr_o, ovf); end
    do_start(8'd2, 1'b0, 1'b0);
    enb = 1'b1;
    step(); step();
    vecs++; if (cntr_o !== 8'd2) begin errs++; $display("FAIL co_pre_term got %0d want 2", cntr_o); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    vecs++; if ({cntr_o, ovf, busy} !== {8'd2, 1'b0, 1'b0}) begin errs++; $display("FAIL co_stop_term got cntr=%0d ovf=%b busy=%b want 2/0/0", cntr_o, ovf, busy); end
    vecs++; if (ovf_cnt === 4'd1 || ovf_sticky !== 1'b1) begin errs++; $display("FAIL co_pre_clr got cnt=%0d sticky=%b want cnt!=1 sticky=1", ovf_cnt, ovf_sticky); end
    do_start(8'd1, 1'b0, 1'b0);
    enb = 1'b1;
    step();
    vecs++; if (cntr_o !== 8'd1) begin errs++; $display("FAIL co_c1 got %0d want 1", cntr_o); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vecs++; if ({ovf, ovf_sticky, ovf_cnt, cntr_o} !== {1'b1, 1'b1, 4'd1, 8'd0}) begin errs++; $display("FAIL co_clr_set got ovf=%b sticky=%b cnt=%0d cntr=%0d want 1/1/1/0", ovf, ovf_sticky, ovf_cnt, cntr_o); end
    enb = 1'b0;
  endtask

  task automatic test_restart();
    do_start(8'd9, 1'b0, 1'b0);
    enb = 1'b1;
    repeat (5) step();
    vecs++; if (cntr_o !== 8'd5) begin errs++; $display("FAIL rs_c5 got %0d want 5", cntr_o); end
    start = 1'b1;
    step();
    start = 1'b0;
    vecs++; if ({cntr_o, ovf, busy} !== {8'd0, 1'b0, 1'b1}) begin errs++; $display("FAIL rs_restart got cntr=%0d ovf=%b busy=%b want 0/0/1", cntr_o, ovf, busy); end
    step();
    vecs++; if (cntr_o !== 8'd1) begin errs++; $display("FAIL rs_c1 got %0d want 1", cntr_o); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if ({cntr_o, ovf, busy} !== {8'd1, 1'b0, 1'b0}) begin errs++; $display("FAIL rs_idle_enb got cntr=%0d ovf=%b busy=%b want 1/0/0", cntr_o, ovf, busy); end
    end
    enb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; enb = 1'b0;
    mode = 1'b0; dir = 1'b0; ovf_clr = 1'b0; count_max = 8'd0;
    #12;
    test_reset();
    test_periodic_up();
    test_oneshot_down();
    test_max_zero();
    test_collisions();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
